sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port 32-bit SRAM macro between the AHB-to-SRAM bridge (primary, cannot be back-pressured at its SRAM side) and one secondary requester (DMA/BIST/debug).
- Also sequences a post-reset or on-demand fill of the whole array with INIT_VALUE.
- Sits between the bridge's SRAM-side outputs and the SRAM macro.
- Generates stall_req; the integrator uses it to gate HREADY into the bridge so a starved secondary requester or an initialisation run gets SRAM cycles.

Parameters:
- AW, 16: byte address width; SRAM word address is AW-2 bits; DEPTH = 2^(AW-2) words.
- MAX_WAIT, 8: number of consecutive cycles the secondary is denied before stall_req is raised; legal range 1..255.
- INIT_EN, 1: 1 means an init run starts automatically after reset; 0 means the run starts only on init_start.
- INIT_VALUE, 32'h0: data written to every word during an init run.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- b_cs  in  1  bridge chip select
- b_addr  in  AW-2  bridge word address
- b_wen  in  4  bridge byte write enables
- b_wdata  in  32  bridge write data
- b_rdata  out  32  read data to bridge
- s_req  in  1  secondary request; held with its payload stable until granted
- s_addr  in  AW-2  secondary word address
- s_wen  in  4  secondary byte write enables; 0 means read
- s_wdata  in  32  secondary write data
- s_gnt  out  1  secondary access issued this cycle
- s_rvalid  out  1  secondary read data valid
- s_rdata  out  32  secondary read data
- init_start  in  1  single-cycle pulse requesting an init run
- init_busy  out  1  init run in progress
- stall_req  out  1  request to hold the bridge's HREADY low
- SRAMCS, SRAMADDR[AW-3:0], SRAMWEN[3:0], SRAMWDATA[31:0]  out  SRAM macro controls
- SRAMRDATA  in  32  SRAM macro read data

Interface: reset HRESETn, asynchronous, active-low; clock HCLK. All state updates on posedge HCLK.

Behaviour:
- Reset values: s_gnt=0, s_rvalid=0, stall_req=0, SRAMCS=0, SRAMWEN=0.
  - INIT_EN=1: init_busy=1 from the first cycle after reset is released.
  - INIT_EN=0: init_busy=0.
- Per-cycle priority, fixed: bridge, then init engine, then secondary.
  - b_cs=1: SRAM outputs are the b_* inputs, passed through combinationally.
  - Else init_busy=1: SRAM gets INIT_VALUE at init_addr with WEN=4'hF.
  - Else s_req=1: SRAM gets the s_* inputs and s_gnt=1. s_gnt is combinational: s_req & ~b_cs & ~init_busy.
  - Else SRAMCS=0.
- Read return: SRAM read latency is 1 cycle.
  - b_rdata = SRAMRDATA at all times.
  - s_rdata = SRAMRDATA.
  - s_rvalid is registered: s_rvalid = (s_gnt & (s_wen==0)) from the previous cycle.
  - Secondary writes produce no s_rvalid.
- Init FSM states IDLE, FILL, DONE:
  - Leaving reset: FILL if INIT_EN=1, otherwise IDLE.
  - IDLE or DONE, on init_start: FILL, with init_addr=0.
  - FILL: init_addr increments only in cycles where the init write is issued (b_cs=0). After the write to DEPTH-1 is issued, go to DONE. No wrap; exactly DEPTH writes.
  - init_start while in FILL is ignored.
  - init_busy = (state==FILL).
- Starvation counter wait_cnt, 8 bits, registered:
  - Increments when s_req & ~s_gnt & ~init_busy.
  - Clears when s_gnt=1 or s_req=0.
  - Saturates at MAX_WAIT.
- stall_req is registered:
  - Set when init_busy, or when wait_cnt reaches MAX_WAIT.
  - Held until the starved access is granted, or the init run completes.
  - Then cleared in the next cycle.
  - A bridge pending write may still use the first stall cycle; arbitration absorbs that by priority.
- Simultaneous events:
  - b_cs during FILL: the bridge wins and the init address holds.
  - s_req during FILL: the secondary waits, and wait_cnt does not count.
- Reset asserted mid-FILL: the FSM returns to its reset state; FILL restarts from address 0 if INIT_EN=1.

Decomposition:
- Shared package sram_arb_pkg holds:
  - the FSM state encoding (IDLE, FILL, DONE);
  - the WEN_ALL=4'hF constant;
  - the wait-counter width constant.
- One natural sub-module, sram_init_seq: the init FSM plus address counter, with outputs init_busy, init_addr and init_we. The arbiter mux and starvation logic stay in the top module.

Test Plan:
- AW=6, INIT_EN=1, release reset with no traffic: exactly 16 writes of 32'h0 at addresses 0..15 with WEN=F. init_busy falls after the write to address 15; stall_req is 1 throughout and 0 after.
- During FILL, b_cs=1 at address 5 for 3 cycles while the init engine is at address 7: SRAM shows the bridge access for those 3 cycles. Init resumes at address 7, all 16 init writes occur, and there are no duplicates.
- Post-init, s_req read at address 3 with b_cs=0: s_gnt=1 in the same cycle. s_rvalid=1 one cycle later, and s_rdata equals the preloaded word.
- MAX_WAIT=4, b_cs held at 1 while s_req=1:
  - stall_req=1 after 4 denied cycles;
  - once b_cs drops, s_gnt=1;
  - stall_req returns to 0 the next cycle.
- init_start pulsed in DONE, with a second pulse mid-FILL: exactly one 16-word fill; the second pulse has no effect.
- HRESETn asserted at init address 9: all outputs go to reset values. After release the fill restarts at address 0 and issues 16 writes.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter and its init sequencer.
//   init_state_t : init engine state encoding (IDLE, FILL, DONE)
//   WEN_ALL      : all four byte lanes written
//   WAIT_W       : width of the secondary starvation counter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } init_state_t;

    localparam logic [3:0] WEN_ALL = 4'hF;
    localparam int         WAIT_W  = 8;

endpackage

// File: rtl/sram_init_seq.sv
// Init sequencer: writes every SRAM word once, either straight out of reset
// or on an init_start pulse. The bridge always wins a cycle, so the address
// only advances on cycles where the init write is actually issued.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no fill requested yet (INIT_EN=0 out of reset)
// FILL  | writing INIT_VALUE at init_addr whenever the bridge is idle
// DONE  | last word written; waiting for another init_start
//
// Ports:
//   HCLK, HRESETn : clock, async active-low reset
//   b_cs          : bridge owns the SRAM this cycle
//   init_start    : single-cycle request for a new fill (ignored in FILL)
//   init_busy     : fill in progress
//   init_addr     : word address of the pending init write
//   init_we       : init write issued this cycle
module sram_init_seq
    import sram_arb_pkg::*;
#(
    parameter int WA      = 14,
    parameter bit INIT_EN = 1'b1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          b_cs,
    input  logic          init_start,
    output logic          init_busy,
    output logic [WA-1:0] init_addr,
    output logic          init_we
);

    init_state_t state;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            if (INIT_EN) state <= FILL;
            else         state <= IDLE;
            init_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (init_start) begin
                        state     <= FILL;
                        init_addr <= '0;
                    end
                end
                FILL: begin
                    if (!b_cs) begin
                        if (init_addr == {WA{1'b1}}) state <= DONE;
                        else                         init_addr <= init_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by reset so no write reaches the macro while reset is held,
    // even though FILL is the reset state when INIT_EN=1.
    assign init_busy = HRESETn & (state == FILL);
    assign init_we   = init_busy & ~b_cs;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a single-port 32-bit SRAM between the AHB bridge (highest priority,
// never back-pressured), the init engine, and one secondary requester.
// stall_req asks the integrator to hold the bridge's HREADY low so that a
// starved secondary or an init run gets SRAM cycles.
//
// Ports:
//   HCLK, HRESETn                        : clock, async active-low reset
//   b_cs/b_addr/b_wen/b_wdata, b_rdata   : bridge SRAM-side access
//   s_req/s_addr/s_wen/s_wdata           : secondary request (held until s_gnt)
//   s_gnt, s_rvalid, s_rdata             : secondary grant and read return
//   init_start, init_busy                : init run control/status
//   stall_req                            : hold-off request for the bridge
//   SRAMCS/SRAMADDR/SRAMWEN/SRAMWDATA    : SRAM macro controls
//   SRAMRDATA                            : SRAM macro read data (1-cycle latency)
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int          AW         = 16,
    parameter int          MAX_WAIT   = 8,
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [31:0] INIT_VALUE = 32'h0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          b_cs,
    input  logic [AW-3:0] b_addr,
    input  logic [3:0]    b_wen,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata,
    input  logic          s_req,
    input  logic [AW-3:0] s_addr,
    input  logic [3:0]    s_wen,
    input  logic [31:0]   s_wdata,
    output logic          s_gnt,
    output logic          s_rvalid,
    output logic [31:0]   s_rdata,
    input  logic          init_start,
    output logic          init_busy,
    output logic          stall_req,
    output logic          SRAMCS,
    output logic [AW-3:0] SRAMADDR,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    input  logic [31:0]   SRAMRDATA
);

    logic [AW-3:0]     init_addr;
    logic              init_we;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              stall_d;

    sram_init_seq #(
        .WA      (AW-2),
        .INIT_EN (INIT_EN)
    ) u_init_seq (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .b_cs       (b_cs),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_addr  (init_addr),
        .init_we    (init_we)
    );

    assign s_gnt = s_req & ~b_cs & ~init_busy;

    always_comb begin
        SRAMCS    = 1'b0;
        SRAMADDR  = '0;
        SRAMWEN   = 4'h0;
        SRAMWDATA = 32'h0;
        if (b_cs) begin
            SRAMCS    = 1'b1;
            SRAMADDR  = b_addr;
            SRAMWEN   = b_wen;
            SRAMWDATA = b_wdata;
        end else if (init_we) begin
            SRAMCS    = 1'b1;
            SRAMADDR  = init_addr;
            SRAMWEN   = WEN_ALL;
            SRAMWDATA = INIT_VALUE;
        end else if (s_gnt) begin
            SRAMCS    = 1'b1;
            SRAMADDR  = s_addr;
            SRAMWEN   = s_wen;
            SRAMWDATA = s_wdata;
        end
    end

    assign b_rdata = SRAMRDATA;
    assign s_rdata = SRAMRDATA;

    // Denied cycles during an init run are not counted: the init run already
    // holds stall_req, and the secondary gets the first free cycle after it.
    always_comb begin
        wait_cnt_d = wait_cnt;
        if (s_gnt || !s_req)
            wait_cnt_d = '0;
        else if (!init_busy && wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt_d = wait_cnt + 1'b1;
    end

    // Raised in the cycle after the MAX_WAIT-th denial; drops the cycle after
    // the grant (counter clears) or after the last init write.
    assign stall_d = init_busy | (wait_cnt_d == WAIT_W'(MAX_WAIT));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt  <= '0;
            stall_req <= 1'b0;
            s_rvalid  <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_d;
            stall_req <= stall_d;
            s_rvalid  <= s_gnt & (s_wen == 4'h0);
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int AW = 6;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          b_cs;
    logic [AW-3:0] b_addr;
    logic [3:0]    b_wen;
    logic [31:0]   b_wdata;
    logic [31:0]   b_rdata;
    logic          s_req;
    logic [AW-3:0] s_addr;
    logic [3:0]    s_wen;
    logic [31:0]   s_wdata;
    logic          s_gnt;
    logic          s_rvalid;
    logic [31:0]   s_rdata;
    logic          init_start;
    logic          init_busy;
    logic          stall_req;
    logic          SRAMCS;
    logic [AW-3:0] SRAMADDR;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic [31:0]   SRAMRDATA;

    int n_vec = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    sram_port_arbiter #(
        .AW         (AW),
        .MAX_WAIT   (4),
        .INIT_EN    (1'b1),
        .INIT_VALUE (32'h0)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .b_cs       (b_cs),
        .b_addr     (b_addr),
        .b_wen      (b_wen),
        .b_wdata    (b_wdata),
        .b_rdata    (b_rdata),
        .s_req      (s_req),
        .s_addr     (s_addr),
        .s_wen      (s_wen),
        .s_wdata    (s_wdata),
        .s_gnt      (s_gnt),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .init_start (init_start),
        .init_busy  (init_busy),
        .stall_req  (stall_req),
        .SRAMCS     (SRAMCS),
        .SRAMADDR   (SRAMADDR),
        .SRAMWEN    (SRAMWEN),
        .SRAMWDATA  (SRAMWDATA),
        .SRAMRDATA  (SRAMRDATA)
    );

    // SRAM macro model: byte-lane writes, 1-cycle read latency.
    logic [31:0] mem [16];
    logic [31:0] rdq = 32'h0;
    assign SRAMRDATA = rdq;

    always @(posedge HCLK) begin
        if (SRAMCS) begin
            rdq <= mem[SRAMADDR];
            for (int i = 0; i < 4; i++)
                if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge HCLK);
        #1;
    endtask

    // Walks one full fill that starts in the current cycle. With traffic:
    // bridge reads address 5 for 3 cycles when the engine is at address 7,
    // a second init_start arrives mid-fill, and the secondary holds a read
    // of address 3 throughout.
    task automatic check_fill(input bit traffic);
        int ia;
        bit bridge;
        ia = 0;
        for (int c = 0; c < (traffic ? 19 : 16); c++) begin
            bridge     = traffic && c >= 7 && c < 10;
            b_cs       = bridge;
            b_addr     = 4'd5;
            b_wen      = 4'h0;
            b_wdata    = 32'h0;
            init_start = traffic && c == 3;
            s_req      = traffic;
            s_addr     = 4'd3;
            s_wen      = 4'h0;
            #1;
            if (bridge) begin
                chk("fill_bridge_addr", SRAMADDR, 32'd5);
                chk("fill_bridge_wen", SRAMWEN, 32'h0);
            end else begin
                chk("fill_addr", SRAMADDR, ia);
                chk("fill_wen", SRAMWEN, 32'hF);
                chk("fill_wdata", SRAMWDATA, 32'h0);
            end
            chk("fill_cs", SRAMCS, 32'd1);
            chk("fill_busy", init_busy, 32'd1);
            chk("fill_stall", stall_req, (c > 0) ? 32'd1 : 32'd0);
            chk("fill_sgnt", s_gnt, 32'd0);
            next_cycle;
            if (!bridge) ia++;
        end
        b_cs = 1'b0;
        init_start = 1'b0;
        #1;
        chk("done_busy", init_busy, 32'd0);
        chk("done_sgnt", s_gnt, traffic ? 32'd1 : 32'd0);
        chk("done_cs", SRAMCS, traffic ? 32'd1 : 32'd0);
        chk("done_stall_hold", stall_req, 32'd1);
        next_cycle;
        s_req = 1'b0;
        #1;
        chk("done_stall_clr", stall_req, 32'd0);
        chk("done_rvalid", s_rvalid, traffic ? 32'd1 : 32'd0);
        if (traffic) chk("done_rdata", s_rdata, 32'h0);
    endtask

    initial begin
        HRESETn = 1'b0;
        b_cs = 1'b0; b_addr = '0; b_wen = 4'h0; b_wdata = 32'h0;
        s_req = 1'b0; s_addr = '0; s_wen = 4'h0; s_wdata = 32'h0;
        init_start = 1'b0;
        #2;
        chk("rst_cs", SRAMCS, 32'd0);
        chk("rst_wen", SRAMWEN, 32'h0);
        chk("rst_sgnt", s_gnt, 32'd0);
        chk("rst_rvalid", s_rvalid, 32'd0);
        chk("rst_stall", stall_req, 32'd0);
        next_cycle;
        next_cycle;
        HRESETn = 1'b1;

        // Automatic fill after reset.
        check_fill(1'b0);

        // Bridge preload of word 3, secondary read, byte write, read back.
        next_cycle;
        b_cs = 1'b1; b_addr = 4'd3; b_wen = 4'hF; b_wdata = 32'hCAFE_0003;
        #1;
        chk("pre_cs", SRAMCS, 32'd1);
        chk("pre_wdata", SRAMWDATA, 32'hCAFE_0003);
        next_cycle;
        b_cs = 1'b0; b_wen = 4'h0;
        s_req = 1'b1; s_addr = 4'd3; s_wen = 4'h0;
        #1;
        chk("srd_gnt", s_gnt, 32'd1);
        chk("srd_addr", SRAMADDR, 32'd3);
        chk("srd_wen", SRAMWEN, 32'h0);
        next_cycle;
        s_addr = 4'd2; s_wen = 4'b0011; s_wdata = 32'h1234_BEEF;
        #1;
        chk("srd_rvalid", s_rvalid, 32'd1);
        chk("srd_rdata", s_rdata, 32'hCAFE_0003);
        chk("srd_brdata", b_rdata, 32'hCAFE_0003);
        chk("swr_gnt", s_gnt, 32'd1);
        chk("swr_wen", SRAMWEN, 32'h3);
        next_cycle;
        s_req = 1'b0;
        b_cs = 1'b1; b_addr = 4'd2; b_wen = 4'h0;
        #1;
        chk("swr_no_rvalid", s_rvalid, 32'd0);
        chk("swr_stall", stall_req, 32'd0);
        next_cycle;
        b_cs = 1'b0;
        #1;
        chk("swr_readback", b_rdata, 32'h0000_BEEF);

        // Starvation: bridge holds the SRAM for 6 cycles, MAX_WAIT=4.
        next_cycle;
        for (int k = 0; k < 8; k++) begin
            b_cs = (k < 6); b_addr = 4'd1; b_wen = 4'h0;
            s_req = (k < 7); s_addr = 4'd4; s_wen = 4'h0;
            #1;
            if (k < 7) chk("starve_gnt", s_gnt, (k == 6) ? 32'd1 : 32'd0);
            if (k < 7) chk("starve_stall", stall_req, (k >= 4) ? 32'd1 : 32'd0);
            if (k == 7) chk("starve_stall_clr", stall_req, 32'd0);
            if (k == 7) chk("starve_rvalid", s_rvalid, 32'd1);
            next_cycle;
        end

        // init_start from DONE, with bridge and secondary traffic mid-fill.
        init_start = 1'b1;
        #1;
        chk("start_cs", SRAMCS, 32'd0);
        chk("start_busy", init_busy, 32'd0);
        next_cycle;
        check_fill(1'b1);

        // Reset asserted while the engine sits at address 9.
        next_cycle;
        init_start = 1'b1;
        #1;
        next_cycle;
        init_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("abort_addr", SRAMADDR, c);
            if (c < 9) next_cycle;
        end
        HRESETn = 1'b0;
        #1;
        chk("abort_cs", SRAMCS, 32'd0);
        chk("abort_wen", SRAMWEN, 32'h0);
        chk("abort_busy", init_busy, 32'd0);
        chk("abort_stall", stall_req, 32'd0);
        chk("abort_sgnt", s_gnt, 32'd0);
        chk("abort_rvalid", s_rvalid, 32'd0);
        next_cycle;
        next_cycle;
        HRESETn = 1'b1;
        check_fill(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
